// File: rtl/streebog_host_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : streebog_host_packer                                         |
// | Description : Packs a host byte stream into 512-bit blocks for the         |
// |               Streebog core and returns the normalised digest.             |
// |               Optional watchdog: define STREEBOG_HOST_TIMEOUT_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module streebog_host_packer #(
  parameter int DATA_WIDTH     = 512,
  parameter int WORD_W         = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            start_i,
  input  logic                                            hash_len_i,
  input  logic [WORD_W-1:0]                               s_data_i,
  input  logic                                            s_valid_i,
  output logic                                            s_ready_o,
  input  logic                                            s_last_i,
  input  logic [((WORD_W > 8) ? $clog2(WORD_W/8) : 1)-1:0] s_bytes_i,
  input  logic                                            s_empty_i,
  output logic                                            fsm_start_req_o,
  input  logic                                            fsm_start_ack_i,
  output logic [DATA_WIDTH-1:0]                           message_o,
  output logic                                            mes_valid_o,
  input  logic                                            mes_ready_i,
  output logic                                            mes_last_o,
  output logic [9:0]                                      mes_last_len_o,
  output logic                                            hash_len_o,
  input  logic [DATA_WIDTH-1:0]                           hash_i,
  input  logic                                            hash_valid_i,
  output logic                                            hash_ready_o,
  output logic [DATA_WIDTH-1:0]                           digest_o,
  output logic                                            digest_valid_o,
  input  logic                                            digest_ready_i,
  output logic                                            busy_o,
  output logic                                            err_o
);

  localparam int BPW    = WORD_W / 8;
  localparam int NWORDS = DATA_WIDTH / WORD_W;
  localparam int SB_W   = (WORD_W > 8) ? $clog2(WORD_W/8) : 1;
  localparam int PTR_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int HALF   = DATA_WIDTH / 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [DATA_WIDTH-1:0] r_digest;
  logic [PTR_W-1:0]      r_ptr;
  logic                  r_last;
  logic [9:0]            r_len;
  logic                  r_req;
  logic                  r_ack_seen;
  logic                  r_hash_seen;
  logic                  r_hash_len;

  logic                  w_blk_acc;
  logic                  w_hash_acc;
  logic                  w_ack_evt;
  logic                  w_ack_done;
  logic                  w_hash_done;
  logic                  w_ptr_full;
  logic                  w_timeout;
  logic [SB_W:0]         w_nbytes;
  logic [6:0]            w_bytes_total;
  logic [WORD_W-1:0]     w_word;
  logic [DATA_WIDTH-1:0] w_digest_cap;

  assign w_blk_acc   = (r_state == S_SEND) && mes_ready_i;
  assign w_hash_acc  = (r_state == S_WAIT) && hash_valid_i;
  assign w_ack_evt   = r_req && fsm_start_ack_i;
  assign w_ack_done  = r_ack_seen || w_ack_evt;
  assign w_hash_done = r_hash_seen || w_hash_acc;
  assign w_ptr_full  = (r_ptr == PTR_W'(NWORDS-1));

  // Bytes carried by the incoming word; a zero byte count on the last word means a full word.
  always_comb begin
    w_nbytes = (SB_W+1)'(BPW);
    if (s_last_i && s_empty_i)
      w_nbytes = '0;
    else if (s_last_i && (s_bytes_i != '0))
      w_nbytes = {1'b0, s_bytes_i};
  end

  assign w_bytes_total = 7'(r_ptr) * 7'(BPW) + 7'(w_nbytes);

  always_comb begin
    w_word = '0;
    for (int b = 0; b < BPW; b++) begin
      if (b < int'(w_nbytes))
        w_word[b*8 +: 8] = s_data_i[b*8 +: 8];
    end
  end

  // 256-bit digests live in the upper half of the core output.
  assign w_digest_cap = r_hash_len ? hash_i : {{HALF{1'b0}}, hash_i[DATA_WIDTH-1 -: HALF]};

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    s_ready_o      = 1'b0;
    mes_valid_o    = 1'b0;
    hash_ready_o   = 1'b0;
    digest_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i)
          w_state_next = S_FILL;
      end
      S_FILL: begin
        s_ready_o = 1'b1;
        if (s_valid_i && (s_last_i || w_ptr_full))
          w_state_next = S_SEND;
      end
      S_SEND: begin
        mes_valid_o = 1'b1;
        if (w_timeout)
          w_state_next = S_IDLE;
        else if (mes_ready_i)
          w_state_next = r_last ? S_WAIT : S_FILL;
      end
      S_WAIT: begin
        hash_ready_o = 1'b1;
        if (w_timeout)
          w_state_next = S_IDLE;
        else if (w_ack_done && w_hash_done)
          w_state_next = S_DONE;
      end
      S_DONE: begin
        digest_valid_o = 1'b1;
        if (digest_ready_i)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_buf       <= '0;
      r_digest    <= '0;
      r_ptr       <= '0;
      r_last      <= 1'b0;
      r_len       <= '0;
      r_req       <= 1'b0;
      r_ack_seen  <= 1'b0;
      r_hash_seen <= 1'b0;
      r_hash_len  <= 1'b0;
    end else begin
      // The request is held only until the core acknowledges it, independent of block flow.
      if (w_ack_evt) begin
        r_req      <= 1'b0;
        r_ack_seen <= 1'b1;
      end
      if (w_timeout)
        r_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_req       <= 1'b1;
            r_ack_seen  <= 1'b0;
            r_hash_seen <= 1'b0;
            r_hash_len  <= hash_len_i;
            r_buf       <= '0;
            r_ptr       <= '0;
            r_last      <= 1'b0;
            r_len       <= '0;
          end
        end
        S_FILL: begin
          if (s_valid_i) begin
            r_buf[r_ptr*WORD_W +: WORD_W] <= w_word;
            if (s_last_i) begin
              r_last <= 1'b1;
              r_len  <= {w_bytes_total, 3'b000};
            end else if (w_ptr_full) begin
              r_last <= 1'b0;
              r_len  <= '0;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        S_SEND: begin
          if (w_blk_acc && !r_last && !w_timeout) begin
            r_buf <= '0;
            r_ptr <= '0;
          end
        end
        S_WAIT: begin
          if (w_hash_acc && !r_hash_seen) begin
            r_hash_seen <= 1'b1;
            r_digest    <= w_digest_cap;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STREEBOG_HOST_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] r_timer;
  logic             r_err;
  logic             w_counting;
  logic             w_hs;

  assign w_counting = (r_state == S_SEND) || (r_state == S_WAIT);
  assign w_hs       = w_blk_acc || w_hash_acc || w_ack_evt;
  assign w_timeout  = w_counting && !w_hs && (r_timer == TMR_W'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      if (!w_counting || w_hs || w_timeout)
        r_timer <= '0;
      else
        r_timer <= r_timer + 1'b1;
      if ((r_state == S_IDLE) && start_i)
        r_err <= 1'b0;
      else if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  assign message_o       = r_buf;
  assign mes_last_o      = r_last;
  assign mes_last_len_o  = r_len;
  assign fsm_start_req_o = r_req;
  assign hash_len_o      = r_hash_len;
  assign digest_o        = r_digest;
  assign busy_o          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_streebog_host_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_streebog_host_packer                                      |
// | Description : Scoreboard bench with a behavioural hash-core responder.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_streebog_host_packer;

  localparam int DW = 512;
  localparam int WW = 64;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          hash_len_i = 1'b0;
  logic [WW-1:0] s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic          s_last_i = 1'b0;
  logic [2:0]    s_bytes_i = '0;
  logic          s_empty_i = 1'b0;
  logic          fsm_start_req_o;
  logic          fsm_start_ack_i = 1'b0;
  logic [DW-1:0] message_o;
  logic          mes_valid_o;
  logic          mes_ready_i = 1'b1;
  logic          mes_last_o;
  logic [9:0]    mes_last_len_o;
  logic          hash_len_o;
  logic [DW-1:0] hash_i = '0;
  logic          hash_valid_i = 1'b0;
  logic          hash_ready_o;
  logic [DW-1:0] digest_o;
  logic          digest_valid_o;
  logic          digest_ready_i = 1'b1;
  logic          busy_o;
  logic          err_o;

  always #5 clk = ~clk;

  streebog_host_packer #(.DATA_WIDTH(DW), .WORD_W(WW), .TIMEOUT_CYCLES(64)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hash_len_i(hash_len_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_last_i(s_last_i),
    .s_bytes_i(s_bytes_i), .s_empty_i(s_empty_i),
    .fsm_start_req_o(fsm_start_req_o), .fsm_start_ack_i(fsm_start_ack_i),
    .message_o(message_o), .mes_valid_o(mes_valid_o), .mes_ready_i(mes_ready_i),
    .mes_last_o(mes_last_o), .mes_last_len_o(mes_last_len_o), .hash_len_o(hash_len_o),
    .hash_i(hash_i), .hash_valid_i(hash_valid_i), .hash_ready_o(hash_ready_o),
    .digest_o(digest_o), .digest_valid_o(digest_valid_o), .digest_ready_i(digest_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_data_q [$];
  logic          exp_last_q [$];
  logic [9:0]    exp_len_q  [$];
  logic [DW-1:0] exp_dig_q  [$];
  logic          exp_hlen = 1'b0;

  logic [DW-1:0] cur_hash = '0;
  int            stall_left = 0;
  int            ack_cnt = 0;
  bit            ack_en = 1'b1;
  bit            hash_pending = 1'b0;
  bit            hash_taken = 1'b0;
  int            hash_dly = 0;
  bit            mon_hold = 1'b0;
  logic [DW-1:0] mon_held = '0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural core: delayed ack pulse, optional block back-pressure, hash after final block.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (fsm_start_ack_i)
        fsm_start_ack_i = 1'b0;
      else if (fsm_start_req_o && ack_en) begin
        if (ack_cnt == 3) begin
          fsm_start_ack_i = 1'b1;
          ack_cnt = 0;
        end else
          ack_cnt++;
      end
      if (mes_valid_o && stall_left > 0) begin
        mes_ready_i = 1'b0;
        stall_left--;
      end else
        mes_ready_i = 1'b1;
      if (hash_taken) begin
        hash_valid_i = 1'b0;
        hash_taken = 1'b0;
      end else if (hash_pending) begin
        if (hash_dly == 0) begin
          hash_valid_i = 1'b1;
          hash_i = cur_hash;
          hash_pending = 1'b0;
        end else
          hash_dly--;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_i) begin
      if (mes_valid_o) begin
        if (mon_hold) check_val("blk_stable", message_o, mon_held);
        if (mes_ready_i) begin
          mon_hold = 1'b0;
          if (exp_data_q.size() == 0)
            check_val("blk_unexpected", DW'(exp_data_q.size()), DW'(1));
          else begin
            check_val("blk_data", message_o, exp_data_q.pop_front());
            check_val("blk_last", DW'(mes_last_o), DW'(exp_last_q.pop_front()));
            check_val("blk_len", DW'(mes_last_len_o), DW'(exp_len_q.pop_front()));
            check_val("hash_len", DW'(hash_len_o), DW'(exp_hlen));
          end
          if (mes_last_o) begin
            hash_pending = 1'b1;
            hash_dly = 3;
          end
        end else begin
          check_val("send_sready", DW'(s_ready_o), DW'(0));
          mon_hold = 1'b1;
          mon_held = message_o;
        end
      end
      if (hash_valid_i && hash_ready_o) hash_taken = 1'b1;
      if (digest_valid_o && digest_ready_i) begin
        if (exp_dig_q.size() == 0)
          check_val("dig_unexpected", DW'(exp_dig_q.size()), DW'(1));
        else
          check_val("digest", digest_o, exp_dig_q.pop_front());
      end
    end
  end

  // abort_at >= 0: reset after that many words; -2: watchdog expected, no digest.
  task automatic send_msg(input int n, input bit hlen, input int stall, input int abort_at);
    logic [7:0]    m [$];
    logic [DW-1:0] blk;
    logic [WW-1:0] data;
    int nblk, nw, k;
    m = {};
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
    nblk = (n == 0) ? 1 : (n + 63) / 64;
    nw   = (n == 0) ? 1 : (n + 7) / 8;
    if (abort_at < 0) begin
      for (int b = 0; b < nblk; b++) begin
        blk = '0;
        for (int i = 0; i < 64 && b*64 + i < n; i++) blk[i*8 +: 8] = m[b*64 + i];
        exp_data_q.push_back(blk);
        exp_last_q.push_back(b == nblk - 1);
        exp_len_q.push_back((b == nblk - 1) ? 10'(8 * (n - b*64)) : 10'd0);
      end
      for (int i = 0; i < 16; i++) cur_hash[i*32 +: 32] = $urandom;
      if (abort_at == -1)
        exp_dig_q.push_back(hlen ? cur_hash : {256'b0, cur_hash[511:256]});
      exp_hlen = hlen;
    end
    stall_left = stall;
    @(posedge clk); #1;
    start_i = 1'b1;
    hash_len_i = hlen;
    @(posedge clk); #1;
    start_i = 1'b0;
    hash_len_i = ~hlen;
    for (int w = 0; w < nw; w++) begin
      if (w == abort_at) begin
        s_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        fsm_start_ack_i = 1'b0;
        ack_cnt = 0;
        @(negedge clk);
        check_val("rst_busy", DW'(busy_o), DW'(0));
        check_val("rst_req", DW'(fsm_start_req_o), DW'(0));
        check_val("rst_sready", DW'(s_ready_o), DW'(0));
        check_val("rst_msg", message_o, '0);
        return;
      end
      data = {$urandom, $urandom};
      for (int i = 0; i < 8; i++)
        if (w*8 + i < n) data[i*8 +: 8] = m[w*8 + i];
      s_data_i  = data;
      s_valid_i = 1'b1;
      s_last_i  = (w == nw - 1);
      s_empty_i = (n == 0);
      s_bytes_i = (w == nw - 1) ? 3'((n - w*8) % 8) : 3'd0;
      k = 0;
      @(negedge clk);
      while (!s_ready_o && k < 200) begin
        k++;
        @(negedge clk);
      end
      if (!s_ready_o) begin
        check_val("sready_timeout", DW'(s_ready_o), DW'(1));
        s_valid_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_empty_i = 1'b0;
    @(negedge clk);
    check_val("last_to_valid", DW'(mes_valid_o), DW'(1));
    k = 0;
    while (busy_o && k < 1000) begin
      k++;
      @(negedge clk);
    end
    check_val("done_idle", DW'(busy_o), DW'(0));
    check_val("blkq_empty", DW'(exp_data_q.size()), DW'(0));
    check_val("digq_empty", DW'(exp_dig_q.size()), DW'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_val("rst_state_busy", DW'(busy_o), DW'(0));
    check_val("rst_state_sready", DW'(s_ready_o), DW'(0));
    check_val("rst_state_mvalid", DW'(mes_valid_o), DW'(0));
    check_val("rst_state_req", DW'(fsm_start_req_o), DW'(0));
    check_val("rst_state_dvalid", DW'(digest_valid_o), DW'(0));
    check_val("rst_state_hready", DW'(hash_ready_o), DW'(0));
    check_val("rst_state_msg", message_o, '0);
    check_val("rst_state_digest", digest_o, '0);
    check_val("rst_state_len", DW'(mes_last_len_o), DW'(0));
    check_val("rst_state_err", DW'(err_o), DW'(0));

    send_msg(63,  1'b1, 0, -1);
    send_msg(63,  1'b0, 0, -1);
    send_msg(72,  1'b1, 0, -1);
    send_msg(64,  1'b1, 0, -1);
    send_msg(0,   1'b1, 0, -1);
    send_msg(20,  1'b1, 5, -1);
    send_msg(130, 1'b0, 2, -1);
    send_msg(128, 1'b1, 0, -1);
    send_msg(40,  1'b1, 0, 3);
    send_msg(17,  1'b0, 0, -1);
`ifdef STREEBOG_HOST_TIMEOUT_EN
    ack_en = 1'b0;
    send_msg(8, 1'b1, 0, -2);
    check_val("tmo_err", DW'(err_o), DW'(1));
    check_val("tmo_req", DW'(fsm_start_req_o), DW'(0));
    ack_en = 1'b1;
    send_msg(9, 1'b1, 0, -1);
    check_val("tmo_err_clr", DW'(err_o), DW'(0));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
